// File: rtl/fir_mac_scheduler_if.sv
// rtl/fir_mac_scheduler_if.sv - sample request, MAC control and result bundle of fir_mac_scheduler
// sat_flag exists only when FIR_SCHED_SAT_EN is defined.
interface fir_mac_scheduler_if #(
  parameter int NCH  = 2,
  parameter int DW   = 8,
  parameter int TAPW = 4,
  parameter int ACCW = 36
);
  logic [NCH-1:0]    req;
  logic [NCH*DW-1:0] sample_in;
  logic [NCH-1:0]    ack;
  logic              dl_shift;
  logic [DW-1:0]     dl_data;
  logic              mac_clr;
  logic              mac_en;
  logic [1:0]        mac_ch;
  logic [TAPW-1:0]   tap_idx;
  logic [ACCW-1:0]   mac_acc;
  logic [DW-1:0]     z;
  logic              z_valid;
  logic [1:0]        z_ch;
  logic              busy;
`ifdef FIR_SCHED_SAT_EN
  logic              sat_flag;

  modport master (
    input  req, sample_in, mac_acc,
    output ack, dl_shift, dl_data, mac_clr, mac_en, mac_ch, tap_idx,
    output z, z_valid, z_ch, busy, sat_flag
  );

  modport slave (
    output req, sample_in, mac_acc,
    input  ack, dl_shift, dl_data, mac_clr, mac_en, mac_ch, tap_idx,
    input  z, z_valid, z_ch, busy, sat_flag
  );
`else
  modport master (
    input  req, sample_in, mac_acc,
    output ack, dl_shift, dl_data, mac_clr, mac_en, mac_ch, tap_idx,
    output z, z_valid, z_ch, busy
  );

  modport slave (
    output req, sample_in, mac_acc,
    input  ack, dl_shift, dl_data, mac_clr, mac_en, mac_ch, tap_idx,
    input  z, z_valid, z_ch, busy
  );
`endif
endinterface

// File: rtl/fir_mac_scheduler.sv
// rtl/fir_mac_scheduler.sv - round-robin scheduler sharing one 16-tap FIR MAC between channels
// Define FIR_SCHED_SAT_EN for saturating rounding and the sat_flag output.
module fir_mac_scheduler #(
  parameter int NCH   = 2,
  parameter int DW    = 8,
  parameter int NTAPS = 16,
  parameter int TAPW  = 4,
  parameter int ACCW  = 36,
  parameter int FRAC  = 12
) (
  input logic                 clk,
  input logic                 reset_n,
  fir_mac_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLR, S_MAC, S_DRAIN, S_ROUND, S_OUT
  } state_t;

  state_t          state_q, state_d;
  logic [TAPW-1:0] tap_q;
  logic [1:0]      rr_q;
  logic            sat_q;

  logic            grant_vld;
  logic [1:0]      grant_ch;
  logic [1:0]      rr_next;
  int              idx;
  logic            req_bit;

  logic [NCH-1:0]  ack_d;
  logic            dl_shift_d, mac_clr_d, mac_en_d, z_valid_d, busy_d;
  logic [DW-1:0]   dl_data_d, z_d;
  logic [1:0]      mac_ch_d, z_ch_d;
  logic [TAPW-1:0] tap_idx_d;
  logic [DW-1:0]   round_z;
  logic            round_sat;

  // Search upward from rr_q with wrap; the first requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = 2'd0;
    idx       = 0;
    req_bit   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      idx     = (int'(rr_q) + i) % NCH;
      req_bit = |(bus.req & (NCH'(1) << idx));
      if (!grant_vld && req_bit) begin
        grant_vld = 1'b1;
        grant_ch  = 2'(idx);
      end
    end
    rr_next = (grant_ch == 2'(NCH-1)) ? 2'd0 : grant_ch + 2'd1;
  end

`ifdef FIR_SCHED_SAT_EN
  localparam int RSW = ACCW - FRAC + 1;
  localparam logic signed [RSW-1:0] ZMAX = RSW'((1 << (DW-1)) - 1);
  localparam logic signed [RSW-1:0] ZMIN = ~ZMAX;
  logic signed [RSW-1:0] rs;
  logic                  unused_acc_bits;

  assign unused_acc_bits = ^bus.mac_acc[FRAC-2:0];

  always_comb begin
    rs = $signed({bus.mac_acc[ACCW-1], bus.mac_acc[ACCW-1:FRAC]})
       + $signed({{(RSW-1){1'b0}}, bus.mac_acc[FRAC-1]});
    round_z   = rs[DW-1:0];
    round_sat = 1'b0;
    if (rs > ZMAX) begin
      round_z   = {1'b0, {(DW-1){1'b1}}};
      round_sat = 1'b1;
    end else if (rs < ZMIN) begin
      round_z   = {1'b1, {(DW-1){1'b0}}};
      round_sat = 1'b1;
    end
  end
`else
  logic unused_acc_bits;

  assign unused_acc_bits = ^{bus.mac_acc[ACCW-1:FRAC+DW], bus.mac_acc[FRAC-2:0]};

  always_comb begin
    round_z   = bus.mac_acc[FRAC+DW-1:FRAC] + DW'(bus.mac_acc[FRAC-1]);
    round_sat = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tap_q   <= '0;
      rr_q    <= 2'd0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && grant_vld) rr_q <= rr_next;
      if (state_q == S_CLR) tap_q <= '0;
      else if (state_q == S_MAC) tap_q <= tap_q + TAPW'(1);
      if (state_q == S_ROUND) sat_q <= round_sat;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_vld) state_d = S_LOAD;
      S_LOAD:  state_d = S_CLR;
      S_CLR:   state_d = S_MAC;
      S_MAC:   if (tap_q == TAPW'(NTAPS-1)) state_d = S_DRAIN;
      S_DRAIN: state_d = S_ROUND;
      S_ROUND: state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the current state and registered, so each
  // strobe appears one cycle after its state is entered.
  always_comb begin
    ack_d      = '0;
    dl_data_d  = bus.dl_data;
    mac_ch_d   = bus.mac_ch;
    if (state_q == S_IDLE && grant_vld) begin
      ack_d     = NCH'(1) << grant_ch;
      dl_data_d = DW'(bus.sample_in >> (int'(grant_ch) * DW));
      mac_ch_d  = grant_ch;
    end
    dl_shift_d = (state_q == S_LOAD);
    mac_clr_d  = (state_q == S_CLR);
    mac_en_d   = (state_q == S_MAC);
    tap_idx_d  = (state_q == S_MAC) ? tap_q : '0;
    z_d        = (state_q == S_ROUND) ? round_z : bus.z;
    z_ch_d     = (state_q == S_ROUND) ? bus.mac_ch : bus.z_ch;
    z_valid_d  = (state_q == S_OUT);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.ack      <= '0;
      bus.dl_shift <= 1'b0;
      bus.dl_data  <= '0;
      bus.mac_clr  <= 1'b0;
      bus.mac_en   <= 1'b0;
      bus.mac_ch   <= 2'd0;
      bus.tap_idx  <= '0;
      bus.z        <= '0;
      bus.z_valid  <= 1'b0;
      bus.z_ch     <= 2'd0;
      bus.busy     <= 1'b0;
`ifdef FIR_SCHED_SAT_EN
      bus.sat_flag <= 1'b0;
`endif
    end else begin
      bus.ack      <= ack_d;
      bus.dl_shift <= dl_shift_d;
      bus.dl_data  <= dl_data_d;
      bus.mac_clr  <= mac_clr_d;
      bus.mac_en   <= mac_en_d;
      bus.mac_ch   <= mac_ch_d;
      bus.tap_idx  <= tap_idx_d;
      bus.z        <= z_d;
      bus.z_valid  <= z_valid_d;
      bus.z_ch     <= z_ch_d;
      bus.busy     <= busy_d;
`ifdef FIR_SCHED_SAT_EN
      bus.sat_flag <= (state_q == S_OUT) && sat_q;
`endif
    end
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// tb/tb_fir_mac_scheduler.sv - scoreboard bench for fir_mac_scheduler with a behavioural MAC
module tb_fir_mac_scheduler;
  localparam int NCH = 2, DW = 8, NTAPS = 16, TAPW = 4, ACCW = 36, FRAC = 12;
  localparam int LAT = NTAPS + 5;
`ifdef FIR_SCHED_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct { int ch; logic [7:0] z; logic sat; bit b2b; } exp_t;
  typedef struct { int ch; logic [7:0] z; logic sat; int ack_cyc; } job_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fir_mac_scheduler_if #(.NCH(NCH), .DW(DW), .TAPW(TAPW), .ACCW(ACCW)) bus ();

  fir_mac_scheduler #(
    .NCH(NCH), .DW(DW), .NTAPS(NTAPS), .TAPW(TAPW), .ACCW(ACCW), .FRAC(FRAC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  exp_t exp_q[$];
  job_t res_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_tot[NCH] = '{default: 0};
  int ack_cnt[NCH] = '{default: 0};
  logic [NCH-1:0] pulse = '0;
  logic signed [ACCW-1:0] ch_step[NCH];
  logic [DW-1:0] smp[NCH];
  logic signed [ACCW-1:0] acc_m;
  int last_zv_cyc = -100;
  int en_cnt = 0;
  int mon_g;
  exp_t mon_e;
  job_t mon_j;

  always_comb begin
    bus.req = '0;
    bus.sample_in = '0;
    for (int k = 0; k < NCH; k++) begin
      bus.req[k] = (req_tot[k] > ack_cnt[k]) | pulse[k];
      bus.sample_in[k*DW +: DW] = smp[k];
    end
  end

  assign bus.mac_acc = acc_m;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc_m <= '0;
    else if (bus.mac_clr) acc_m <= '0;
    else if (bus.mac_en) acc_m <= acc_m + ch_step[bus.mac_ch];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      res_q.delete();
      en_cnt = 0;
    end else begin
      if (bus.ack != '0) begin
        check("ack_onehot", 64'($countones(bus.ack)), 1);
        mon_g = 0;
        for (int k = NCH - 1; k >= 0; k--) if (bus.ack[k]) mon_g = k;
        ack_cnt[mon_g]++;
        if (exp_q.size() == 0) begin
          check("ack_unexpected", 64'(bus.ack), 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("grant_ch", 64'(mon_g), 64'(mon_e.ch));
          check("ack_while_busy", 64'(res_q.size()), 0);
          if (mon_e.b2b) check("b2b_gap", 64'(cyc - last_zv_cyc), 1);
          check("grant_mac_ch", 64'(bus.mac_ch), 64'(mon_e.ch));
          check("grant_dl_data", 64'(bus.dl_data), 64'(smp[mon_e.ch]));
          res_q.push_back('{ch: mon_e.ch, z: mon_e.z, sat: mon_e.sat, ack_cyc: cyc});
          en_cnt = 0;
        end
      end
      if (bus.dl_shift) begin
        if (res_q.size() == 0) check("dl_shift_unexpected", 64'(bus.dl_shift), 0);
        else begin
          check("dl_shift_time", 64'(cyc - res_q[0].ack_cyc), 1);
          check("dl_shift_data", 64'(bus.dl_data), 64'(smp[res_q[0].ch]));
        end
      end
      if (bus.mac_clr && res_q.size() != 0)
        check("mac_clr_time", 64'(cyc - res_q[0].ack_cyc), 2);
      if (bus.mac_en) begin
        check("tap_idx", 64'(bus.tap_idx), 64'(en_cnt % NTAPS));
        en_cnt++;
      end
      if (bus.z_valid) begin
        if (res_q.size() == 0) check("z_valid_unexpected", 64'(bus.z_valid), 0);
        else begin
          mon_j = res_q.pop_front();
          check("z", 64'(bus.z), 64'(mon_j.z));
          check("z_ch", 64'(bus.z_ch), 64'(mon_j.ch));
          check("latency", 64'(cyc - mon_j.ack_cyc), 64'(LAT));
          check("mac_en_count", 64'(en_cnt), 64'(NTAPS));
`ifdef FIR_SCHED_SAT_EN
          check("sat_flag", 64'(bus.sat_flag), 64'(mon_j.sat));
`endif
        end
        last_zv_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || res_q.size() != 0 || bus.busy) && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 64'(n < 200), 1);
  endtask

  task automatic wait_mac(input string tag, input int tap);
    int n = 0;
    while (!(bus.mac_en && int'(bus.tap_idx) == tap) && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_mac_timeout"}, 64'(n < 100), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 64'({bus.ack, bus.dl_shift, bus.dl_data, bus.mac_clr, bus.mac_en, bus.mac_ch,
                    bus.tap_idx, bus.z, bus.z_valid, bus.z_ch, bus.busy}), 0);
`ifdef FIR_SCHED_SAT_EN
    check({tag, "_sat"}, 64'(bus.sat_flag), 0);
`endif
  endtask

  initial begin
    smp[0] = 8'h10;
    smp[1] = 8'hA5;
    ch_step[0] = '0;
    ch_step[1] = '0;
    repeat (3) tick();
    check_all_zero("reset_outputs");
    reset_n = 1'b1;
    repeat (2) tick();

    // single request on channel 0
    ch_step[0] = 36'h1280;
    exp_q.push_back('{ch: 0, z: 8'h13, sat: 1'b0, b2b: 1'b0});
    req_tot[0]++;
    wait_done("single");

    // rounding edge on channel 1
    ch_step[1] = 36'hFF80;
    exp_q.push_back('{ch: 1, z: SAT ? 8'h7F : 8'h00, sat: SAT, b2b: 1'b0});
    req_tot[1]++;
    wait_done("round_edge");

    // both channels request continuously for four results
    ch_step[0] = -36'sh1380;
    ch_step[1] = 36'h0340;
    exp_q.push_back('{ch: 0, z: 8'hED, sat: 1'b0, b2b: 1'b0});
    exp_q.push_back('{ch: 1, z: 8'h03, sat: 1'b0, b2b: 1'b1});
    exp_q.push_back('{ch: 0, z: 8'hED, sat: 1'b0, b2b: 1'b1});
    exp_q.push_back('{ch: 1, z: 8'h03, sat: 1'b0, b2b: 1'b1});
    req_tot[0] += 2;
    req_tot[1] += 2;
    wait_done("contention");

    // channel 1 raises its request during channel 0's MAC
    ch_step[0] = 36'h80;
    ch_step[1] = -36'sh10000;
    exp_q.push_back('{ch: 0, z: 8'h01, sat: 1'b0, b2b: 1'b0});
    exp_q.push_back('{ch: 1, z: SAT ? 8'h80 : 8'h00, sat: SAT, b2b: 1'b1});
    req_tot[0]++;
    wait_mac("late", 3);
    req_tot[1]++;
    wait_done("late");

    // channel 0 pulses its request for one cycle while busy
    ch_step[1] = 36'h100;
    exp_q.push_back('{ch: 1, z: 8'h01, sat: 1'b0, b2b: 1'b0});
    req_tot[1]++;
    wait_mac("withdrawn", 4);
    pulse[0] = 1'b1;
    tick();
    pulse[0] = 1'b0;
    wait_done("withdrawn");
    repeat (5) tick();

    // reset in the middle of a computation
    ch_step[0] = 36'h1280;
    exp_q.push_back('{ch: 0, z: 8'h13, sat: 1'b0, b2b: 1'b0});
    req_tot[0]++;
    wait_mac("reset_mid", 7);
    reset_n = 1'b0;
    #1;
    check_all_zero("reset_mid_outputs");
    exp_q.delete();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    ch_step[1] = 36'h200;
    exp_q.push_back('{ch: 1, z: 8'h02, sat: 1'b0, b2b: 1'b0});
    req_tot[1]++;
    wait_done("after_reset");

    repeat (5) tick();
    check("scoreboard_empty", 64'(exp_q.size() + res_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
